// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the block fetch sequencer.
//   - Default geometry (address/data width, words per block, byte offset).
//   - FSM state type.
//   - blk_mask(): mask that clears the in-block offset bits of a byte address.
package fetch_pkg;

    localparam int unsigned ADDR_W_DEF   = 32;
    localparam int unsigned DATA_W_DEF   = 32;
    localparam int unsigned N_WORDS_DEF  = 32;
    localparam int unsigned BYTE_OFS_DEF = 2;
    localparam int unsigned MASK_W       = 64;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StDone
    } fetch_state_e;

    // Ones above the low_bits offset field, zeros inside it.
    function automatic logic [MASK_W-1:0] blk_mask(input int unsigned low_bits);
        return ~((MASK_W'(1) << low_bits) - MASK_W'(1));
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: N_WORDS x DATA_W register file holding one fetched block.
// Ports:
//   clk, rst          clock, asynchronous active-high clear of every entry
//   we, widx, wdata   single write port
//   rd_idx, rd_data   asynchronous read port
module fetch_buffer #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned N_WORDS = 32,
    localparam int unsigned IDX_W  = $clog2(N_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [IDX_W-1:0]  widx,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [N_WORDS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(N_WORDS); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[widx] <= wdata;
        end
    end

    assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/block_fetch_sequencer.sv
// block_fetch_sequencer: fetches one aligned block of N_WORDS words, one read per request,
// into a local buffer read back through rd_idx/rd_data.
// Configuration macro: BURST_WRAP_EN -- critical-word-first order (first word is the one
//   addressed by base_addr, wrapping inside the block); undefined -> order 0..N_WORDS-1.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start, base_addr         fetch request (sampled only when idle) and an address in the block
//   busy, done               fetch in progress / one-cycle completion pulse
//   mem_addr, mem_req        read request to memory, held until mem_gnt
//   mem_gnt                  memory accepted the request
//   mem_rvalid, mem_rdata    read response (only taken while waiting for it)
//   rd_idx, rd_data          buffer read port, indexed by word offset in the block
module block_fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned N_WORDS  = N_WORDS_DEF,
    parameter int unsigned BYTE_OFS = BYTE_OFS_DEF,
    localparam int unsigned IDX_W   = $clog2(N_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_req,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    localparam int unsigned LOW_W = IDX_W + BYTE_OFS;
    localparam int unsigned CNT_W = $clog2(N_WORDS + 1);
    localparam logic [ADDR_W-1:0] BLK_MASK = ADDR_W'(blk_mask(LOW_W));

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] blk_q, blk_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  first_idx;
    logic              buf_we;

`ifdef BURST_WRAP_EN
    assign first_idx = base_addr[LOW_W-1:BYTE_OFS];
`else
    assign first_idx = '0;
`endif

    // The index field never carries into the block base.
    assign mem_addr = blk_q | (ADDR_W'(idx_q) << BYTE_OFS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            blk_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        busy    = 1'b0;
        done    = 1'b0;
        mem_req = 1'b0;
        buf_we  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    blk_d   = base_addr & BLK_MASK;
                    idx_d   = first_idx;
                    cnt_d   = '0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                // A simultaneous rvalid belongs to no request and is dropped.
                if (mem_gnt) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                busy = 1'b1;
                if (mem_rvalid) begin
                    buf_we = 1'b1;
                    cnt_d  = cnt_q + CNT_W'(1);
                    // Completion is judged by words received, not by the wrapping index.
                    if (cnt_q == CNT_W'(N_WORDS - 1)) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = StIssue;
                    end
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    fetch_buffer #(
        .DATA_W  (DATA_W),
        .N_WORDS (N_WORDS)
    ) u_buffer (
        .clk     (clk),
        .rst     (rst),
        .we      (buf_we),
        .widx    (idx_q),
        .wdata   (mem_rdata),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_block_fetch_sequencer.sv
// Testbench for block_fetch_sequencer: randomized memory model, address scoreboard and
// block-level reference model of the expected buffer contents.
module tb_block_fetch_sequencer;

    localparam int N = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic        busy;
    logic        done;
    logic [31:0] mem_addr;
    logic        mem_req;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [4:0]  rd_idx;
    logic [31:0] rd_data;

    block_fetch_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .busy       (busy),
        .done       (done),
        .mem_addr   (mem_addr),
        .mem_req    (mem_req),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .rd_idx     (rd_idx),
        .rd_data    (rd_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard queues and reference buffer.
    logic [31:0] exp_addr_q[$];
    int          exp_done_q[$];
    logic [31:0] exp_buf[N];

    // Memory model controls.
    int          fixed_gnt_wait = 0;
    int          max_rdelay = 0;
    bit          spurious_en = 1'b0;
    logic [31:0] salt = 32'h0;
    int          words_done = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory model: grants after a chosen delay, answers once per grant with addr ^ salt,
    // and optionally throws stray rvalid pulses while no response is owed.
    initial begin
        int          req_age;
        int          gnt_target;
        int          rdelay;
        bit          pending;
        logic [31:0] pend_addr;
        req_age    = 0;
        gnt_target = 0;
        rdelay     = 0;
        pending    = 1'b0;
        pend_addr  = '0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge clk);
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
            if (rst) req_age = 0;
            if (pending) begin
                if (rdelay == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = pend_addr ^ salt;
                    pending    = 1'b0;
                    words_done++;
                end else begin
                    rdelay--;
                end
            end else if (mem_req && !rst) begin
                if (req_age == 0) begin
                    gnt_target = (fixed_gnt_wait >= 0) ? fixed_gnt_wait : int'($urandom_range(0, 3));
                end
                if (req_age >= gnt_target) begin
                    mem_gnt   = 1'b1;
                    pending   = 1'b1;
                    pend_addr = mem_addr;
                    rdelay    = int'($urandom_range(0, max_rdelay));
                    req_age   = 0;
                end else begin
                    req_age++;
                end
                if (spurious_en && ($urandom % 4 == 0)) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = $urandom;
                end
            end else if (spurious_en && ($urandom % 4 == 0)) begin
                mem_rvalid = 1'b1;
                mem_rdata  = $urandom;
            end
        end
    end

    // Monitor: compares every presented request and every done pulse against the scoreboard.
    initial begin
        bit prev_done;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                if (mem_req) begin
                    check("busy_in_issue", busy, 1);
                    if (exp_addr_q.size() == 0) begin
                        check("unexpected_req", mem_addr, 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        check("mem_addr", mem_addr, exp_addr_q[0]);
                        if (mem_gnt) void'(exp_addr_q.pop_front());
                    end
                end
                if (done) begin
                    check("done_expected", exp_done_q.size() != 0, 1);
                    if (exp_done_q.size() != 0) void'(exp_done_q.pop_front());
                    check("busy_at_done", busy, 0);
                    check("words_left_at_done", exp_addr_q.size(), 0);
                    check("done_one_cycle", prev_done, 0);
                    done_cnt++;
                    done_cyc = cyc;
                end
                prev_done = done;
            end else begin
                prev_done = 1'b0;
            end
        end
    end

    // Reference model of one fetch: request order and final buffer contents.
    task automatic expect_fetch(input logic [31:0] base);
        logic [31:0] blk;
        int unsigned first;
        blk = base & ~(32'(N * 4) - 32'd1);
`ifdef BURST_WRAP_EN
        first = (base >> 2) % N;
`else
        first = 0;
`endif
        for (int k = 0; k < N; k++) begin
            exp_addr_q.push_back(blk + 32'(((first + k) % N) * 4));
        end
        exp_done_q.push_back(1);
        for (int i = 0; i < N; i++) begin
            exp_buf[i] = (blk + 32'(i * 4)) ^ salt;
        end
    endtask

    task automatic check_buf(input string name);
        for (int i = 0; i < N; i++) begin
            rd_idx = 5'(i);
            #1;
            check(name, rd_data, exp_buf[i]);
        end
    endtask

    // Runs one fetch; optionally pulses start with alt_base at loop cycle intf_at (if >= 0).
    task automatic run_fetch(input logic [31:0] base, input int intf_at,
                             input logic [31:0] alt_base, output int lat);
        int  s;
        int  d0;
        bit  seen;
        @(posedge clk);
        #1;
        expect_fetch(base);
        start     = 1'b1;
        base_addr = base;
        s         = cyc;
        d0        = done_cnt;
        seen      = 1'b0;
        lat       = -1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < 3000 && !seen; k++) begin
            @(posedge clk);
            #1;
            start = (k == intf_at);
            if (k == intf_at) base_addr = alt_base;
            if (done_cnt != d0) seen = 1'b1;
        end
        start = 1'b0;
        check("done_timeout", seen, 1);
        if (seen) lat = done_cyc - s;
    endtask

    initial begin
        int lat;
        int w0;
        bit hit;
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        rd_idx    = '0;
        for (int i = 0; i < N; i++) exp_buf[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check_buf("rst_buf");
        rst = 1'b0;

        // Minimum-latency fetch, data equals address.
        fixed_gnt_wait = 0;
        max_rdelay     = 0;
        salt           = 32'h0;
        run_fetch(32'h0000_1234, -1, 32'h0, lat);
        check("min_latency", lat, 65);
        rd_idx = 5'd5;
        #1;
        check("rd_idx5", rd_data, 32'h0000_1214);
        check_buf("buf_t1");

        // Grant held off three cycles per word: address must not move while waiting.
        fixed_gnt_wait = 3;
        salt           = 32'hA5A5_0000;
        run_fetch(32'h0040_0F08, -1, 32'h0, lat);
        check("gnt_wait_latency", lat, 1 + N * (3 + 1 + 1));
        check_buf("buf_t3");

        // Start pulsed mid-fetch with another base is ignored.
        fixed_gnt_wait = 0;
        salt           = 32'h0000_FFFF;
        run_fetch(32'h0001_0088, 20, 32'h8000_0040, lat);
        check("ignored_start_latency", lat, 65);
        check_buf("buf_t4");

        // Reset after ten words.
        fixed_gnt_wait = -1;
        max_rdelay     = 1;
        salt           = 32'h1357_9BDF;
        @(posedge clk);
        #1;
        expect_fetch(32'h00AB_C07C);
        base_addr = 32'h00AB_C07C;
        start     = 1'b1;
        w0        = words_done;
        @(posedge clk);
        #1;
        start = 1'b0;
        hit   = 1'b0;
        for (int k = 0; k < 500 && !hit; k++) begin
            @(negedge clk);
            #3;
            if (words_done - w0 >= 10) hit = 1'b1;
        end
        check("word10_reached", hit, 1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_req", mem_req, 0);
        check("rst_mid_done", done, 0);
        exp_addr_q.delete();
        exp_done_q.delete();
        for (int i = 0; i < N; i++) exp_buf[i] = '0;
        check_buf("buf_after_rst");
        @(negedge clk);
        #3;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("idle_after_rst", busy, 0);
        check_buf("buf_late_rvalid");
        run_fetch(32'h00AB_C07C, -1, 32'h0, lat);
        check_buf("buf_after_refetch");

        // Random fetches with random timing and stray rvalid pulses.
        spurious_en = 1'b1;
        max_rdelay  = 2;
        for (int t = 0; t < 6; t++) begin
            salt = $urandom;
            run_fetch($urandom, (t % 2 == 0) ? int'($urandom_range(0, 40)) : -1,
                      $urandom, lat);
            check("rand_latency_min", lat >= 65, 1);
            check_buf("buf_rand");
        end
        spurious_en = 1'b0;
        repeat (4) @(posedge clk);
        check("stray_done", exp_done_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
